// File: rtl/common_logic_cells.sv
// Basic cells: resettable D-latch, D flip-flop and 4-bit carry-lookahead adder.
// Define COMMON_ADD_REG_EN to register the adder outputs (one cycle latency).
module common_logic_cells #(
  parameter logic DFF_RST_VAL   = 1'b0,
  parameter logic LATCH_RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_en,
  input  logic       latch_d,
  output logic       latch_q,
  output logic       latch_q_n,
  input  logic       dff_d,
  output logic       dff_q,
  output logic       dff_q_n,
  input  logic [3:0] add_a,
  input  logic [3:0] add_b,
  input  logic       add_cin,
  output logic [3:0] add_sum,
  output logic       add_cout
);

  // Reset dominates the enable so the latch cannot be transparent while reset is low.
  always_latch begin
    if (!reset) begin
      latch_q <= LATCH_RST_VAL;
    end else if (latch_en) begin
      latch_q <= latch_d;
    end
  end

  assign latch_q_n = ~latch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dff_q <= DFF_RST_VAL;
    end else begin
      dff_q <= dff_d;
    end
  end

  assign dff_q_n = ~dff_q;

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:1] carry;
  logic [3:0] sum_comb;

  assign gen  = add_a & add_b;
  assign prop = add_a ^ add_b;

  // Each carry is a flat two-level sum of products; no carry feeds another.
  assign carry[1] = gen[0] | (prop[0] & add_cin);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & add_cin);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & add_cin);
  assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & add_cin);

  assign sum_comb = prop ^ {carry[3], carry[2], carry[1], add_cin};

`ifdef COMMON_ADD_REG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_sum  <= 4'b0000;
      add_cout <= 1'b0;
    end else begin
      add_sum  <= sum_comb;
      add_cout <= carry[4];
    end
  end
`else
  assign add_sum  = sum_comb;
  assign add_cout = carry[4];
`endif

endmodule

// File: tb/tb_common_logic_cells.sv
// Directed bench for common_logic_cells: latch, flip-flop and adder (both builds).
module tb_common_logic_cells;

  logic       clk;
  logic       reset;
  logic       latch_en;
  logic       latch_d;
  logic       latch_q;
  logic       latch_q_n;
  logic       dff_d;
  logic       dff_q;
  logic       dff_q_n;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  int checks   = 0;
  int failures = 0;

  common_logic_cells dut (
    .clk       (clk),
    .reset     (reset),
    .latch_en  (latch_en),
    .latch_d   (latch_d),
    .latch_q   (latch_q),
    .latch_q_n (latch_q_n),
    .dff_d     (dff_d),
    .dff_q     (dff_q),
    .dff_q_n   (dff_q_n),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_latch(input string tag, input logic exp);
    chk(tag, {6'd0, latch_q, latch_q_n}, {6'd0, exp, ~exp});
  endtask

  task automatic chk_dff(input string tag, input logic exp);
    chk(tag, {6'd0, dff_q, dff_q_n}, {6'd0, exp, ~exp});
  endtask

  // Applies operands on a falling edge and samples once the result is due.
  task automatic add_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic [4:0] exp);
    @(negedge clk);
    add_a   = a;
    add_b   = b;
    add_cin = cin;
`ifdef COMMON_ADD_REG_EN
    @(posedge clk);
`endif
    #1;
    chk(tag, {3'd0, add_cout, add_sum}, {3'd0, exp});
  endtask

  initial begin
    logic [4:0] ref_sum;
    reset    = 1'b0;
    latch_en = 1'b1;
    latch_d  = 1'b1;
    dff_d    = 1'b1;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;

    #3;
    chk_latch("rst_latch_en_high", 1'b0);
    chk_dff("rst_dff", 1'b0);
    @(posedge clk); #1;
    chk_dff("rst_dff_clocked", 1'b0);

    // Release reset between edges; dff must wait for the next rising edge.
    latch_en = 1'b0;
    #5;
    reset = 1'b1;
    #1;
    chk_dff("dff_after_release_no_edge", 1'b0);
    chk_latch("latch_en0_holds_reset", 1'b0);
    @(posedge clk); #1;
    chk_dff("dff_first_edge", 1'b1);

    latch_en = 1'b1; latch_d = 1'b1; #1;
    chk_latch("latch_transparent_1", 1'b1);
    latch_en = 1'b0; #1; latch_d = 1'b0; #1;
    chk_latch("latch_hold_1", 1'b1);
    latch_en = 1'b1; latch_d = 1'b0; #1;
    chk_latch("latch_transparent_0", 1'b0);
    latch_d = 1'b1; #1;
    chk_latch("latch_follow_d", 1'b1);

    // Reset overrides an open latch; release re-follows d.
    reset = 1'b0; #1;
    chk_latch("latch_rst_override", 1'b0);
    reset = 1'b1; #1;
    chk_latch("latch_refollow", 1'b1);

    // Hold state then reset mid-hold discards it.
    latch_en = 1'b0; #1;
    reset = 1'b0; #1;
    chk_latch("latch_rst_mid_hold", 1'b0);
    reset = 1'b1; #1;
    chk_latch("latch_stays_reset", 1'b0);

    // Flip-flop sequence.
    @(negedge clk); dff_d = 1'b1;
    @(posedge clk); #1;
    chk_dff("dff_d1", 1'b1);
    @(negedge clk); dff_d = 1'b0; #1;
    chk_dff("dff_hold_between_edges", 1'b1);
    @(posedge clk); #1;
    chk_dff("dff_d0", 1'b0);
    @(negedge clk); dff_d = 1'b1;
    @(posedge clk); #1;
    chk_dff("dff_d1_again", 1'b1);
    #2;
    reset = 1'b0; #1;
    chk_dff("dff_rst_mid_cycle", 1'b0);
    @(posedge clk); #1;
    chk_dff("dff_rst_held", 1'b0);
    @(negedge clk); reset = 1'b1;

    // Adder boundary vectors.
    add_check("add_7_1_0",   4'd7,  4'd1,  1'b0, 5'b0_1000);
    add_check("add_14_7_0",  4'd14, 4'd7,  1'b0, 5'b1_0101);
    add_check("add_15_1_0",  4'd15, 4'd1,  1'b0, 5'b1_0000);
    add_check("add_10_5_1",  4'd10, 4'd5,  1'b1, 5'b1_0000);
    add_check("add_12_10_0", 4'd12, 4'd10, 1'b0, 5'b1_0110);
    add_check("add_8_8_0",   4'd8,  4'd8,  1'b0, 5'b1_0000);
    add_check("add_15_15_1", 4'd15, 4'd15, 1'b1, 5'b1_1111);
    add_check("add_0_0_0",   4'd0,  4'd0,  1'b0, 5'b0_0000);

    for (int i = 0; i < 512; i++) begin
      ref_sum = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
      add_check("add_exhaustive", i[3:0], i[7:4], i[8], ref_sum);
    end

`ifdef COMMON_ADD_REG_EN
    add_check("add_reg_0", 4'd0, 4'd0, 1'b0, 5'b0_0000);
    @(negedge clk);
    add_a = 4'd1; add_b = 4'd1; add_cin = 1'b1; #1;
    chk("add_reg_before_edge", {3'd0, add_cout, add_sum}, 8'h00);
    @(posedge clk); #1;
    chk("add_reg_after_edge", {3'd0, add_cout, add_sum}, 8'h03);
    #2;
    reset = 1'b0; #1;
    chk("add_reg_async_rst", {3'd0, add_cout, add_sum}, 8'h00);
    reset = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
